stream_mux_arb: RTL
===================

# stream_mux_arb

Parametrised N-to-1 registered stream multiplexer for the 8-bit ALU datapath. It is the next generation of the fixed 8:1 bit mux: it has configurable data width and channel count, and a valid/ready handshake on every channel. It runs in one of two modes, externally selected or round-robin arbitrated. It sits between multiple operand/result producers and a single ALU or writeback consumer, and delivers one registered word per cycle at full throughput.

## Interface
- WIDTH, 8, data bits per channel.
- NCH, 8, number of input channels; legal range 2..16.
- SELW, $clog2(NCH), width of channel index (localparam, derived).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- mode  in  1  0 = external select, 1 = round-robin arbitration.
- sel  in  SELW  channel index used in mode 0.
- in_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready (combinational).
- out_data  out  WIDTH  registered output word.
- out_chan  out  SELW  index of the channel that supplied out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  downstream accepts this cycle.

## Operation
- Output stage: a single register holding out_data, out_chan and out_valid.
- load_en = !out_valid || out_ready. The register may load whenever it is empty or is being drained in the same cycle.
- Winner selection (combinational):
  - mode 0: the winner is sel, but only if sel < NCH and in_valid[sel]=1; otherwise there is no winner.
  - mode 1: the winner is the first k with in_valid[k]=1, searching (last+1) mod NCH upward and wrapping.
- in_ready[k] = load_en && (k == winner). At most one bit of in_ready is high. in_ready is 0 for every channel when there is no winner or load_en=0.
- Transfer on channel k is in_valid[k] && in_ready[k]. On a transfer:
  - out_data <= in_data[k]
  - out_chan <= k
  - out_valid <= 1
  - last <= k
- If load_en=1 and there is no winner: out_valid <= 0. out_data and out_chan hold their previous values.
- If load_en=0: the register holds. out_data, out_chan and out_valid are stable while out_valid && !out_ready.
- last (round-robin pointer, SELW bits):
  - updates on every transfer in either mode, so switching mode 0 to mode 1 resumes fairness after the last-served channel.
  - is otherwise unchanged.
- Mode or sel changes take effect in the same cycle's winner computation. A word already in the output register is unaffected.
- Non-power-of-2 NCH: an out-of-range sel in mode 0 gives no winner. The round-robin wrap is mod NCH, never mod 2^SELW.

## Timing
- Reset (rst_n=0, async): out_valid=0, out_data=0, out_chan=0, last=NCH-1 (so channel 0 has first priority after reset). in_ready follows combinationally, so with out_valid=0 it depends only on the inputs.
- Reset asserted mid-stream drops the held word; there is no replay.
- The first rising edge after rst_n deasserts may perform a transfer.
- Latency: 1 cycle. Input accepted at edge N gives out_valid=1 with that data after edge N.
- Throughput: 1 word/cycle while out_ready=1 and a winner exists.
- Simultaneous drain and load (out_valid=1, out_ready=1, winner present): the old word leaves and the new word loads at the same edge, with no bubble.
- Backpressure (out_valid=1, out_ready=0): all in_ready=0, and no channel state changes.
- No combinational path from out_ready to out_data or out_valid. Combinational paths exist from out_ready, in_valid, sel and mode to in_ready.

## Test plan
- Reset: hold rst_n=0 with arbitrary inputs; release. Required: out_valid=0, out_data=0x00, out_chan=0. With mode=1 and all in_valid=1, the first accepted channel is 0.
- Mode 0 select: WIDTH=8, NCH=8, sel=5, in_data ch5=0xA5, only in_valid[5]=1, out_ready=1. Required: in_ready=8'b0010_0000; next cycle out_data=0xA5, out_chan=5, out_valid=1. Then sel=3 with in_valid[3]=0: in_ready=0, and out_valid drops to 0 after one edge.
- Round-robin fairness: mode=1, all in_valid=1, out_ready=1 for 10 cycles. Required: out_chan sequence 0,1,2,3,4,5,6,7,0,1 with one word per cycle. Then with only channels 2 and 6 valid: 2,6,2,6.
- Backpressure: fill the register with 0x3C, hold out_ready=0 for 4 cycles while in_valid toggles. Required: out_data=0x3C, out_chan and out_valid=1 stable, in_ready=0 throughout. Release out_ready: next word loads at that edge.
- Non-power-of-2 and reset mid-stream: NCH=5, mode=1, all valid. Required: out_chan 0,1,2,3,4,0, with no index 5-7 ever. In mode 0, sel=6 gives no winner. Assert rst_n low while out_valid=1: out_valid=0 immediately (before the next clock edge).

Source files
------------

// File: rtl/stream_mux_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_arb_if
// Brief    : Handshake bundle between N stream producers and one consumer,
//            as seen by the stream_mux_arb multiplexer.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_mux_arb_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8
);
    localparam int SELW = $clog2(NCH);

    logic                   mode;
    logic [SELW-1:0]        sel;
    logic [NCH*WIDTH-1:0]   in_data;
    logic [NCH-1:0]         in_valid;
    logic [NCH-1:0]         in_ready;
    logic [WIDTH-1:0]       out_data;
    logic [SELW-1:0]        out_chan;
    logic                   out_valid;
    logic                   out_ready;

    // master: the surrounding producers/consumer; slave: the multiplexer
    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface
`default_nettype wire

// File: rtl/stream_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_arb
// Brief    : N-to-1 registered stream mux, external select or round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_arb #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8
) (
    input  wire             clk,
    input  wire             rst_n,
    stream_mux_arb_if.slave bus
);
    localparam int SELW = $clog2(NCH);
    localparam logic [SELW-1:0] c_last_rst = SELW'(NCH - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;
    logic [SELW-1:0]  r_last;

    logic             w_load_en;
    logic             w_has_winner;
    logic [SELW-1:0]  w_winner;
    logic [WIDTH-1:0] w_win_data;
    logic [NCH-1:0]   w_in_ready;

    assign w_load_en = !r_out_valid || bus.out_ready;

    // Round-robin: a lowest-index pass over channels at or below last, then a
    // pass over channels above last that overrides it, so the nearest
    // successor of last wins and the wrap stays mod NCH.
    always_comb begin
        w_has_winner = 1'b0;
        w_winner     = '0;
        if (!bus.mode) begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.sel == k[SELW-1:0] && bus.in_valid[k]) begin
                    w_has_winner = 1'b1;
                    w_winner     = k[SELW-1:0];
                end
            end
        end else begin
            for (int k = NCH - 1; k >= 0; k--) begin
                if (bus.in_valid[k] && (k[SELW-1:0] <= r_last)) begin
                    w_has_winner = 1'b1;
                    w_winner     = k[SELW-1:0];
                end
            end
            for (int k = NCH - 1; k >= 0; k--) begin
                if (bus.in_valid[k] && (k[SELW-1:0] > r_last)) begin
                    w_has_winner = 1'b1;
                    w_winner     = k[SELW-1:0];
                end
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        w_in_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            if (w_winner == k[SELW-1:0]) begin
                w_win_data    = bus.in_data[k*WIDTH +: WIDTH];
                w_in_ready[k] = w_load_en && w_has_winner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_last      <= c_last_rst;
        end else if (w_load_en) begin
            if (w_has_winner) begin
                r_out_data  <= w_win_data;
                r_out_chan  <= w_winner;
                r_out_valid <= 1'b1;
                r_last      <= w_winner;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire
